seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
- Downstream consumer of the R2R/PWM measurement subsystem's 16-bit output word (scaled binary, BCD, raw or averaged code).
- Time-multiplexes the word onto a 4-digit common-anode seven-segment display, one hex/BCD nibble per digit.
- Latches new data only at frame boundaries, so a digit never shows a mix of old and new values.
- Supports optional leading-zero blanking, per-digit decimal points and a display hold.

Parameters:
- CLOCK_FREQ, 100_000_000, system clock frequency in Hz.
- SCAN_HZ, 1000, per-digit switching rate in Hz. DIGIT_TICKS = CLOCK_FREQ/SCAN_HZ is the number of clocks each digit is lit. DIGIT_TICKS must be ≥ 2; check this at elaboration.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- value_in  input  16  word to display; nibble k drives digit k (digit 0 = rightmost)
- dp_in  input  4  decimal-point enable per digit, bit k = digit k
- blank_lz  input  1  1 = blank leading zero digits
- hold  input  1  1 = freeze displayed data
- anode  output  4  digit enables, active-low, bit k = digit k
- segment  output  7  cathodes, active-low, segment[6:0] = {g,f,e,d,c,b,a}
- dp_n  output  1  decimal-point cathode, active-low

Behaviour:
- One clock. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - tick counter = 0; digit index = 0; latched value = 16'h0000; latched dp = 4'b0000.
  - anode = 4'b1111; segment = 7'h7F; dp_n = 1.
- Tick counter:
  - Counts 0 .. DIGIT_TICKS-1, then wraps to 0.
  - On each wrap the digit index advances 0→1→2→3→0.
- Frame latch:
  - Condition: tick == DIGIT_TICKS-1 and index == 3 and hold == 0.
  - When the condition is true, value_in and dp_in are registered into the latched registers, effective in the cycle the index becomes 0.
  - With hold == 1 the latched registers keep their contents. hold is sampled only at the frame boundary.
  - Changes to value_in, dp_in or hold at any other time have no visible effect until the next frame boundary.
  - The first frame after reset displays the reset latch contents, i.e. value 0.
- Blanking:
  - Digit k (k ≥ 1) is blanked iff all of: blank_lz == 1; latched nibbles k..3 are all zero; latched dp bits k..3 are all zero.
  - Digit 0 is never blanked.
  - blank_lz is sampled live, not latched.
- Output register (outputs are registered; 1-cycle latency from index/latch state to pins):
  - Lit digit: anode = ~(1 << index); segment = decode(latched nibble[index]); dp_n = ~latched_dp[index].
  - Blanked digit: anode = 4'b1111; segment = 7'h7F; dp_n = 1.
  - Exactly one anode bit is low at any time, or none when the digit is blanked.
- Decode table, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Reset asserted mid-scan: all outputs and state return to reset values on the next clock edge. The scan restarts at digit 0, tick 0.

Test Plan:
- Configuration: CLOCK_FREQ=100, SCAN_HZ=25, giving DIGIT_TICKS=4.
- Reset: hold reset for 3 cycles → anode=1111, segment=7F, dp_n=1 throughout. After release with blank_lz=1, the first frame shows digit 0 = 0x40 on anode 1110 and digits 1–3 blanked (anode 1111).
- value_in=16'h1234, dp_in=0, blank_lz=0 → in the second frame, each for 4 cycles:
  - anode 1110 / segment 0x19
  - anode 1101 / segment 0x30
  - anode 1011 / segment 0x24
  - anode 0111 / segment 0x79
  - dp_n=1 throughout.
- value_in=16'h0052, dp_in=4'b0100, blank_lz=1 → digit 3 slot has anode 1111; digit 2 shows 0x40 with dp_n=0; digit 1 shows 0x12; digit 0 shows 0x24.
- value_in changes from 16'h1111 to 16'h2222 while index == 1 → digits 1–3 of the current frame still show 0x79. The next frame shows 0x24 on all digits.
- hold=1 across a frame boundary while value_in changes from 16'hABCD to 16'h0000 → the display keeps showing A/b/C/d. Releasing hold shows 0x0000 from the next frame onward.
- Reset pulsed while index == 2 → reset values on the next cycle. Scanning resumes at digit 0 with the latched value 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scanner. The displayed word and decimal
// points are captured only at frame boundaries, so a frame never mixes old and new data.
module seg7_scan_driver #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int SCAN_HZ    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  input  logic        hold,
  output logic [3:0]  anode,
  output logic [6:0]  segment,
  output logic        dp_n
);

  localparam int DIGIT_TICKS = CLOCK_FREQ / SCAN_HZ;
  localparam int TICK_W      = (DIGIT_TICKS < 2) ? 1 : $clog2(DIGIT_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);

  generate
    if (DIGIT_TICKS < 2) begin : g_bad_ticks
      $error("seg7_scan_driver: CLOCK_FREQ/SCAN_HZ must be at least 2");
    end
  endgenerate

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [TICK_W-1:0] tick_p0;
  logic [1:0]        idx_p0;
  logic [15:0]       value_p0;
  logic [3:0]        dp_p0;
  logic              wrap_p0;
  logic              frame_end_p0;

  assign wrap_p0      = (tick_p0 == TICK_LAST);
  assign frame_end_p0 = wrap_p0 && (idx_p0 == 2'd3) && !hold;

  // Stage p0: scan timing and frame latch
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_p0  <= '0;
      idx_p0   <= 2'd0;
      value_p0 <= 16'h0000;
      dp_p0    <= 4'b0000;
    end else begin
      tick_p0 <= wrap_p0 ? '0 : tick_p0 + 1'b1;
      if (wrap_p0)
        idx_p0 <= idx_p0 + 2'd1;
      if (frame_end_p0) begin
        value_p0 <= value_in;
        dp_p0    <= dp_in;
      end
    end
  end

  logic [3:0] blank_vec;
  logic [3:0] nibble;
  logic       lit;

  // A digit blanks only if it and every digit to its left hold zero with no dp lit.
  always_comb begin
    blank_vec = 4'b0000;
    for (int k = 1; k < 4; k++) begin
      blank_vec[k] = blank_lz && ((value_p0 >> (4 * k)) == 16'h0000)
                              && ((dp_p0 >> k) == 4'b0000);
    end
  end

  assign nibble = value_p0[idx_p0 * 4 +: 4];
  assign lit    = !blank_vec[idx_p0];

  logic [3:0] anode_p1;
  logic [6:0] segment_p1;
  logic       dp_n_p1;

  // Stage p1: registered pin drive
  always_ff @(posedge clk) begin
    if (reset) begin
      anode_p1   <= 4'b1111;
      segment_p1 <= 7'h7F;
      dp_n_p1    <= 1'b1;
    end else if (lit) begin
      anode_p1   <= ~(4'b0001 << idx_p0);
      segment_p1 <= seg7_decode(nibble);
      dp_n_p1    <= ~dp_p0[idx_p0];
    end else begin
      anode_p1   <= 4'b1111;
      segment_p1 <= 7'h7F;
      dp_n_p1    <= 1'b1;
    end
  end

  assign anode   = anode_p1;
  assign segment = segment_p1;
  assign dp_n    = dp_n_p1;

endmodule
